systolic_controller: RTL and testbench

Sequencer for the weight-stationary Q1.15 systolic array. It accepts a job command, clears the accumulators, and streams ARRAY_SIZE weight rows into the north edge. It then streams activation vectors into the west edge with per-row diagonal skew and drains the pipeline. When the array's accumulators hold the final product, it signals completion. It sits between the memory/fetch logic (valid/ready streams) and the array's control and data edges.

---
 rtl/systolic_controller_if.sv | 27 ++
 rtl/systolic_controller.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_controller_if.sv
// Weight-row and activation-vector stream bundle for systolic_controller.
// master: fetch side (drives valid/data); slave: controller (drives ready).
interface systolic_controller_if #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 4
);
  logic                            w_valid;
  logic                            w_ready;
  logic [ARRAY_SIZE*DATA_BITS-1:0] w_data;
  logic                            a_valid;
  logic                            a_ready;
  logic [ARRAY_SIZE*DATA_BITS-1:0] a_data;

  modport master (
    output w_valid, w_data,
    input  w_ready,
    output a_valid, a_data,
    input  a_ready
  );

  modport slave (
    input  w_valid, w_data,
    output w_ready,
    input  a_valid, a_data,
    output a_ready
  );
endinterface

// File: rtl/systolic_controller.sv
// Weight-stationary systolic array sequencer: clear, load N weight rows,
// stream K skewed activation vectors, drain D cycles, pulse done.
// Ports: clk, reset (sync, active-high), start/len job request,
// busy/done status, bus (slave: w_* weight and a_* activation streams),
// arr_* array control strobes and west/north edge data.
// Macro SYSTOLIC_SKEW_EN: per-row diagonal skew registers, D = 2N-2;
// undefined: lanes pass straight through, D = N-1.
module systolic_controller #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 4,
  parameter int LEN_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LEN_BITS-1:0]             len,
  output logic                            busy,
  output logic                            done,
  systolic_controller_if.slave            bus,
  output logic                            arr_enable,
  output logic                            arr_clear_acc,
  output logic                            arr_load_weights,
  output logic                            arr_compute_enable,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] arr_a_inputs,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] arr_b_inputs
);

  localparam int N     = ARRAY_SIZE;
  localparam int DB    = DATA_BITS;
  localparam int VW    = N * DB;
  localparam int ROW_W = $clog2(N) + 1;
  localparam int DR_W  = $clog2(2 * N) + 1;
`ifdef SYSTOLIC_SKEW_EN
  localparam int DRAIN_CYC = 2 * N - 2;
`else
  localparam int DRAIN_CYC = N - 1;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [ROW_W-1:0]    row_q;
  logic [LEN_BITS-1:0] rem_q;
  logic [DR_W-1:0]     drain_q;

  logic in_idle;
  logic in_clear;
  logic in_load;
  logic in_stream;
  logic in_drain;
  logic in_done;
  logic w_fire;
  logic a_fire;
  logic last_row;
  logic last_vec;
  logic last_drain;
  logic w_ready_o;
  logic a_ready_o;

  logic [VW-1:0] skew_in;
  logic [VW-1:0] skew_out;

  assign in_idle   = (state_q == S_IDLE);
  assign in_clear  = (state_q == S_CLEAR);
  assign in_load   = (state_q == S_LOAD_W);
  assign in_stream = (state_q == S_STREAM);
  assign in_drain  = (state_q == S_DRAIN);
  assign in_done   = (state_q == S_DONE);

  assign w_fire = in_load & bus.w_valid;
  assign a_fire = in_stream & bus.a_valid;

  assign last_row   = (row_q == ROW_W'(N - 1));
  assign last_vec   = (rem_q == LEN_BITS'(1));
  assign last_drain = (drain_q == DR_W'(DRAIN_CYC - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (w_fire && last_row) begin
          // zero-length job skips streaming entirely
          if (rem_q == '0) state_d = S_DONE;
          else             state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (a_fire && last_vec) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_drain) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;

      if (in_idle && start)
        rem_q <= len;
      else if (a_fire)
        rem_q <= rem_q - LEN_BITS'(1);

      if (in_clear)
        row_q <= '0;
      else if (w_fire)
        row_q <= row_q + ROW_W'(1);

      if (in_stream)
        drain_q <= '0;
      else if (in_drain)
        drain_q <= drain_q + DR_W'(1);
    end
  end

  always_comb begin
    arr_enable         = 1'b0;
    arr_clear_acc      = 1'b0;
    arr_load_weights   = 1'b0;
    arr_compute_enable = 1'b0;
    w_ready_o          = 1'b0;
    a_ready_o          = 1'b0;
    done               = 1'b0;
    unique case (1'b1)
      in_clear: begin
        arr_enable    = 1'b1;
        arr_clear_acc = 1'b1;
      end
      in_load: begin
        w_ready_o        = 1'b1;
        arr_enable       = w_fire;
        arr_load_weights = w_fire;
      end
      in_stream: begin
        a_ready_o          = 1'b1;
        arr_enable         = a_fire;
        arr_compute_enable = a_fire;
      end
      in_drain: begin
        arr_enable         = 1'b1;
        arr_compute_enable = 1'b1;
      end
      in_done: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy        = ~in_idle;
  assign bus.w_ready = w_ready_o;
  assign bus.a_ready = a_ready_o;

  assign arr_b_inputs = w_fire ? bus.w_data : '0;

  // zeros enter the west edge on drain cycles and on stream bubbles
  assign skew_in = a_fire ? bus.a_data : '0;

`ifdef SYSTOLIC_SKEW_EN
  logic adv_skew;

  // skew registers advance in lockstep with the array
  assign adv_skew = a_fire | in_drain;

  for (genvar r = 0; r < N; r++) begin : g_skew
    if (r == 0) begin : g_pass
      assign skew_out[0 +: DB] = skew_in[0 +: DB];
    end else begin : g_dly
      logic [DB-1:0] sr_q [r];

      always_ff @(posedge clk) begin
        if (reset || in_clear) begin
          for (int k = 0; k < r; k++)
            sr_q[k] <= '0;
        end else if (adv_skew) begin
          sr_q[0] <= skew_in[r*DB +: DB];
          for (int k = 1; k < r; k++)
            sr_q[k] <= sr_q[k-1];
        end
      end

      assign skew_out[r*DB +: DB] = sr_q[r-1];
    end
  end
`else
  assign skew_out = skew_in;
`endif

  assign arr_a_inputs = (in_stream | in_drain) ? skew_out : '0;

endmodule

// File: tb/tb_systolic_controller.sv
// Scoreboard bench for systolic_controller: driver pushes expected array
// events, negedge monitor pops and compares them plus per-cycle levels.
module tb_systolic_controller;

  localparam int N  = 4;
  localparam int DB = 16;
  localparam int LB = 8;
`ifdef SYSTOLIC_SKEW_EN
  localparam int D = 2 * N - 2;
`else
  localparam int D = N - 1;
`endif

  typedef struct {
    int          cyc;
    bit          is_done;
    bit          clr;
    bit          ld;
    bit          cmp;
    logic [63:0] a;
    logic [63:0] b;
  } rec_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LB-1:0] len;
  logic          busy;
  logic          done;
  logic          arr_enable;
  logic          arr_clear_acc;
  logic          arr_load_weights;
  logic          arr_compute_enable;
  logic [63:0]   arr_a_inputs;
  logic [63:0]   arr_b_inputs;

  systolic_controller_if #(.DATA_BITS(DB), .ARRAY_SIZE(N)) bus ();

  systolic_controller #(
    .DATA_BITS(DB),
    .ARRAY_SIZE(N),
    .LEN_BITS(LB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(len),
    .busy(busy),
    .done(done),
    .bus(bus),
    .arr_enable(arr_enable),
    .arr_clear_acc(arr_clear_acc),
    .arr_load_weights(arr_load_weights),
    .arr_compute_enable(arr_compute_enable),
    .arr_a_inputs(arr_a_inputs),
    .arr_b_inputs(arr_b_inputs)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ph = 0;
  rec_t sbq[$];
  rec_t m;

  logic [63:0] w_tab [N];
  logic [63:0] a_tab [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void push(int c, bit d, bit cl, bit ld, bit cm,
                               logic [63:0] a, logic [63:0] b);
    rec_t r;
    r.cyc = c; r.is_done = d; r.clr = cl; r.ld = ld; r.cmp = cm;
    r.a = a; r.b = b;
    sbq.push_back(r);
  endfunction

  // expected west edge at the j-th stream/drain advance of a K-vector job
  function automatic logic [63:0] exp_a(int j, int k);
    logic [63:0] v;
    logic [63:0] src;
    int          s;
    v = '0;
    for (int r = 0; r < N; r++) begin
`ifdef SYSTOLIC_SKEW_EN
      s = j - r;
`else
      s = j;
`endif
      if (s >= 0 && s < k) begin
        src = a_tab[s];
        v[r*DB +: DB] = src[r*DB +: DB];
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (arr_enable || done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event", {62'b0, done, arr_enable}, 64'd0);
      end else begin
        m = sbq.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(m.cyc));
        chk("done", 64'(done), 64'(m.is_done));
        chk("enable", 64'(arr_enable), 64'(!m.is_done));
        chk("clear", 64'(arr_clear_acc), 64'(m.clr));
        chk("load", 64'(arr_load_weights), 64'(m.ld));
        chk("compute", 64'(arr_compute_enable), 64'(m.cmp));
        chk("a_in", arr_a_inputs, m.a);
        chk("b_in", arr_b_inputs, m.b);
      end
    end else begin
      chk("idle_ctrl", 64'({arr_clear_acc, arr_load_weights,
                            arr_compute_enable}), 64'd0);
      chk("b_idle", arr_b_inputs, 64'd0);
    end
    chk("busy", 64'(busy), 64'(ph != 0));
    chk("w_ready", 64'(bus.w_ready), 64'(ph == 2));
    chk("a_ready", 64'(bus.a_ready), 64'(ph == 3));
    if (ph != 3 && ph != 4)
      chk("a_idle", arr_a_inputs, 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ph: 0 idle, 1 clear, 2 load, 3 stream, 4 drain, 5 done
  task automatic run_job(input int k, input bit [7:0] wbub,
                         input bit [7:0] abub, input bit hold,
                         input int abort_at);
    start = 1'b1;
    len = LB'(k);
    ph = 0;
    push(cyc + 1, 0, 1, 0, 0, 64'd0, 64'd0);
    tick();
    ph = 1;
    if (!hold) start = 1'b0;
    tick();
    ph = 2;
    for (int i = 0; i < N; i++) begin
      if (wbub[i]) begin
        bus.w_valid = 1'b0;
        bus.w_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      bus.w_valid = 1'b1;
      bus.w_data = w_tab[i];
      push(cyc, 0, 0, 1, 0, 64'd0, w_tab[i]);
      tick();
    end
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    start = 1'b0;
    if (k == 0) begin
      ph = 5;
      push(cyc, 1, 0, 0, 0, 64'd0, 64'd0);
      tick();
      ph = 0;
      return;
    end
    ph = 3;
    for (int j = 0; j < k; j++) begin
      if (abort_at == j) begin
        reset = 1'b1;
        bus.a_valid = 1'b0;
        tick();
        reset = 1'b0;
        ph = 0;
        return;
      end
      if (abub[j]) begin
        bus.a_valid = 1'b0;
        bus.a_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
      end
      bus.a_valid = 1'b1;
      bus.a_data = a_tab[j];
      push(cyc, 0, 0, 0, 1, exp_a(j, k), 64'd0);
      tick();
    end
    bus.a_valid = 1'b0;
    bus.a_data = '0;
    ph = 4;
    for (int d = 0; d < D; d++) begin
      push(cyc, 0, 0, 0, 1, exp_a(k + d, k), 64'd0);
      tick();
    end
    ph = 5;
    push(cyc, 1, 0, 0, 0, 64'd0, 64'd0);
    tick();
    ph = 0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    len = 8'd5;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.a_valid = 1'b0;
    bus.a_data = '0;
    w_tab[0] = 64'h1000_2000_3000_4000;
    w_tab[1] = 64'h0800_F000_0400_C000;
    w_tab[2] = 64'h7FFF_8000_0001_FFFF;
    w_tab[3] = 64'h0123_4567_89AB_CDEF;
    a_tab[0] = 64'h4000_0000_C000_2000;
    a_tab[1] = 64'h0001_0002_0003_0004;
    a_tab[2] = 64'h8000_7FFF_8000_7FFF;
    a_tab[3] = 64'h1111_2222_3333_4444;
    for (int i = 4; i < 8; i++) a_tab[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    start = 1'b0;
    tick();

    run_job(4, 8'h00, 8'h00, 1'b0, -1);
    run_job(4, 8'b0101, 8'b0110, 1'b0, -1);
    run_job(0, 8'h00, 8'h00, 1'b0, -1);

    a_tab[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    run_job(1, 8'h00, 8'h00, 1'b0, -1);

    a_tab[0] = 64'h4000_0000_C000_2000;
    run_job(4, 8'h00, 8'h00, 1'b0, 2);
    tick();

    a_tab[3] = 64'h7FFF_0001_8001_0100;
    run_job(3, 8'h00, 8'b0001, 1'b1, -1);
    run_job(2, 8'b1000, 8'h00, 1'b0, -1);

    repeat (4) tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
